// File: rtl/fft_chk_pkg.sv
// Shared types and width helpers for the FFT stream checker.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package fft_chk_pkg;

    // Checker sequencing states
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DRIVE = 3'd1,
        WAIT  = 3'd2,
        DONE  = 3'd3,
        TOUT  = 3'd4
    } state_e;

    // Width of a field able to hold values 0..v-1, never narrower than one bit
    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

    // Widths for the default 32-point build
    localparam int DEF_N_POINTS = 32;
    localparam int DEF_IN_AW    = clog2_min1(DEF_N_POINTS);
    localparam int DEF_ADDR_W   = clog2_min1(2 * DEF_N_POINTS);
    localparam int DEF_CNT_W    = clog2_min1(2 * DEF_N_POINTS + 1);

endpackage

// File: rtl/fft_chk_cmp.sv
// Compares one FFT output word against its golden value; exact or within +/-TOL.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs. Tolerance mode under FFT_CHK_TOLERANCE_EN.
module fft_chk_cmp #(
    parameter int OUT_W = 17,
    parameter int TOL   = 0
) (
    input  logic [OUT_W-1:0] answer_i,
    input  logic [OUT_W-1:0] gold_i,
    output logic             match_o
);

`ifdef FFT_CHK_TOLERANCE_EN
    logic signed [OUT_W:0] diff;
    logic        [OUT_W:0] mag;

    // Signed distance between answer and gold, accepted when within TOL LSBs
    always_comb begin
        diff    = $signed({answer_i[OUT_W-1], answer_i}) - $signed({gold_i[OUT_W-1], gold_i});
        mag     = diff[OUT_W] ? $unsigned(-diff) : $unsigned(diff);
        match_o = (mag <= (OUT_W+1)'(TOL));
    end
`else
    // TOL only matters in tolerance builds
    logic unused_tol;
    assign unused_tol = ^TOL;

    // Exact bitwise equality
    always_comb begin
        match_o = (answer_i == gold_i);
    end
`endif

endmodule

// File: rtl/fft_stream_checker.sv
// Replays a stored input frame into an FFT core and checks its serial output against golden data.
// Latency: first beat one cycle after start is registered; verdict one cycle after last word sampled.
// Backpressure: none; inputs stream without gaps, finish_i taken whenever high. Option: FFT_CHK_TOLERANCE_EN.
module fft_stream_checker
    import fft_chk_pkg::*;
#(
    parameter int N_POINTS    = 32,
    parameter int IN_W        = 11,
    parameter int OUT_W       = 17,
    parameter int TIMEOUT_CYC = 150,
    parameter int TOL         = 0
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       load_en,
    input  logic                                       load_sel,
    input  logic [clog2_min1(2*N_POINTS)-1:0]          load_addr,
    input  logic [OUT_W-1:0]                           load_data,
    input  logic                                       start,
    output logic                                       valid_o,
    output logic [IN_W-1:0]                            x_o,
    input  logic                                       finish_i,
    input  logic [OUT_W-1:0]                           answer_i,
    output logic                                       busy,
    output logic                                       done,
    output logic                                       pass,
    output logic                                       timeout,
    output logic [clog2_min1(2*N_POINTS+1)-1:0]        err_cnt,
    output logic [clog2_min1(2*N_POINTS)-1:0]          first_err_idx
);

    localparam int IN_AW  = clog2_min1(N_POINTS);
    localparam int ADDR_W = clog2_min1(2 * N_POINTS);
    localparam int CNT_W  = clog2_min1(2 * N_POINTS + 1);
    localparam int TC_W   = clog2_min1(TIMEOUT_CYC + 1);

    localparam logic [IN_AW-1:0] IN_LAST  = IN_AW'(N_POINTS - 1);
    localparam logic [CNT_W-1:0] OUT_ALL  = CNT_W'(2 * N_POINTS);
    localparam logic [TC_W-1:0]  TC_LIMIT = TC_W'(TIMEOUT_CYC);

    logic [IN_W-1:0]  in_mem_q   [N_POINTS];
    logic [OUT_W-1:0] gold_mem_q [2*N_POINTS];

    state_e            state_q, state_d;
    logic [IN_AW-1:0]  in_idx_q, in_idx_d;
    logic [CNT_W-1:0]  out_idx_q, out_idx_d;
    logic [TC_W-1:0]   tcnt_q, tcnt_d;
    logic              cmp_vld_q, cmp_vld_d;
    logic              cmp_err_q, cmp_err_d;
    logic [ADDR_W-1:0] cmp_idx_q, cmp_idx_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
    logic [ADDR_W-1:0] first_err_q, first_err_d;
    logic              valid_q, valid_d;
    logic [IN_W-1:0]   x_q, x_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic              tout_q, tout_d;

    logic              active;
    logic              word_match;

    assign active = (state_q == DRIVE) || (state_q == WAIT);

    fft_chk_cmp #(
        .OUT_W (OUT_W),
        .TOL   (TOL)
    ) u_cmp (
        .answer_i (answer_i),
        .gold_i   (gold_mem_q[out_idx_q[ADDR_W-1:0]]),
        .match_o  (word_match)
    );

    // Vector memories: written only while idle or finished, never reset
    always_ff @(posedge clk) begin
        if (load_en && !active) begin
            if (load_sel) begin
                gold_mem_q[load_addr] <= load_data;
            end else begin
                in_mem_q[load_addr[IN_AW-1:0]] <= load_data[IN_W-1:0];
            end
        end
    end

    // Next-state, counters, compare pipeline and registered outputs
    always_comb begin
        state_d     = state_q;
        in_idx_d    = in_idx_q;
        out_idx_d   = out_idx_q;
        tcnt_d      = tcnt_q;
        cmp_vld_d   = 1'b0;
        cmp_err_d   = 1'b0;
        cmp_idx_d   = cmp_idx_q;
        err_cnt_d   = err_cnt_q;
        first_err_d = first_err_q;
        valid_d     = 1'b0;
        x_d         = '0;

        // A compare sampled last cycle retires into the error statistics now
        if (cmp_vld_q && cmp_err_q) begin
            if (err_cnt_q == '0) begin
                first_err_d = cmp_idx_q;
            end
            err_cnt_d = err_cnt_q + 1'b1;
        end

        case (state_q)
            DRIVE, WAIT: begin
                // Extra words beyond the frame length are dropped
                if (finish_i && (out_idx_q < OUT_ALL)) begin
                    cmp_vld_d = 1'b1;
                    cmp_err_d = ~word_match;
                    cmp_idx_d = out_idx_q[ADDR_W-1:0];
                    out_idx_d = out_idx_q + 1'b1;
                end
                if (state_q == DRIVE) begin
                    valid_d = 1'b1;
                    x_d     = in_mem_q[in_idx_q];
                    if (in_idx_q == IN_LAST) begin
                        state_d = WAIT;
                    end else begin
                        in_idx_d = in_idx_q + 1'b1;
                    end
                end
                // Completion takes priority over a coincident timeout
                if ((state_q == WAIT) && (out_idx_q == OUT_ALL)) begin
                    state_d = DONE;
                end else if (tcnt_q == TC_LIMIT) begin
                    state_d = TOUT;
                    valid_d = 1'b0;
                    x_d     = '0;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            default: begin
                if (start) begin
                    state_d     = DRIVE;
                    in_idx_d    = '0;
                    out_idx_d   = '0;
                    tcnt_d      = '0;
                    err_cnt_d   = '0;
                    first_err_d = '0;
                end
            end
        endcase

        busy_d = (state_d == DRIVE) || (state_d == WAIT);
        done_d = (state_d == DONE) || (state_d == TOUT);
        tout_d = (state_d == TOUT);
        pass_d = (state_d == DONE) && (err_cnt_d == '0);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_idx_q    <= '0;
            out_idx_q   <= '0;
            tcnt_q      <= '0;
            cmp_vld_q   <= 1'b0;
            cmp_err_q   <= 1'b0;
            cmp_idx_q   <= '0;
            err_cnt_q   <= '0;
            first_err_q <= '0;
            valid_q     <= 1'b0;
            x_q         <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            tout_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_idx_q    <= in_idx_d;
            out_idx_q   <= out_idx_d;
            tcnt_q      <= tcnt_d;
            cmp_vld_q   <= cmp_vld_d;
            cmp_err_q   <= cmp_err_d;
            cmp_idx_q   <= cmp_idx_d;
            err_cnt_q   <= err_cnt_d;
            first_err_q <= first_err_d;
            valid_q     <= valid_d;
            x_q         <= x_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            tout_q      <= tout_d;
        end
    end

    assign valid_o       = valid_q;
    assign x_o           = x_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign timeout       = tout_q;
    assign err_cnt       = err_cnt_q;
    assign first_err_idx = first_err_q;

endmodule

// File: tb/tb_fft_stream_checker.sv
// Randomised self-checking bench for fft_stream_checker against a frame-level reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_fft_stream_checker;

    localparam int N    = 32;
    localparam int IN_W = 11;
    localparam int OW   = 17;
    localparam int TO   = 150;
    localparam int TOL  = 1;
    localparam int AW   = 6;
    localparam int CW   = 7;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          load_en;
    logic          load_sel;
    logic [AW-1:0] load_addr;
    logic [OW-1:0] load_data;
    logic          start;
    logic          valid_o;
    logic [IN_W-1:0] x_o;
    logic          finish_i;
    logic [OW-1:0] answer_i;
    logic          busy, done, pass, timeout;
    logic [CW-1:0] err_cnt;
    logic [AW-1:0] first_err_idx;

    int n_vec = 0;
    int n_bad = 0;

    logic [IN_W-1:0] ref_in   [N];
    logic [OW-1:0]   ref_gold [2*N];

    fft_stream_checker #(
        .N_POINTS(N), .IN_W(IN_W), .OUT_W(OW), .TIMEOUT_CYC(TO), .TOL(TOL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .load_en(load_en), .load_sel(load_sel),
        .load_addr(load_addr), .load_data(load_data), .start(start),
        .valid_o(valid_o), .x_o(x_o), .finish_i(finish_i), .answer_i(answer_i),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout),
        .err_cnt(err_cnt), .first_err_idx(first_err_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Word acceptance rule as seen from outside the block
    function automatic bit word_ok(input logic [OW-1:0] a, input logic [OW-1:0] g);
`ifdef FFT_CHK_TOLERANCE_EN
        int d;
        d = int'($signed(a)) - int'($signed(g));
        if (d < 0) d = -d;
        return d <= TOL;
`else
        return a == g;
`endif
    endfunction

    task automatic load_word(input bit sel, input int addr, input logic [OW-1:0] data);
        load_en   = 1'b1;
        load_sel  = sel;
        load_addr = AW'(addr);
        load_data = data;
        tick();
        load_en = 1'b0;
    endtask

    // in_mode: 0 ramp, 1 random; gold_mode: 0 zeros, 1 random
    task automatic load_all(input int in_mode, input int gold_mode);
        logic [OW-1:0] d;
        for (int i = 0; i < N; i++) begin
            d = (in_mode == 0) ? OW'(i) : OW'($urandom);
            ref_in[i] = d[IN_W-1:0];
            load_word(1'b0, i, d);
        end
        for (int i = 0; i < 2*N; i++) begin
            d = (gold_mode == 0) ? '0 : OW'($urandom);
            ref_gold[i] = d;
            load_word(1'b1, i, d);
        end
    endtask

    // One frame: words offered from cycle first_c with probability p_fin,
    // forced bad words at err_a/err_b, random corruption with probability p_err.
    task automatic run_frame(input int p_fin, input int first_c, input int err_a,
                             input int err_b, input int p_err, input bit pokes);
        int j, last_e, exp_err, exp_first, c;
        bit exp_done, tmo;
        logic [OW-1:0] w;
        j = 0; last_e = 0; exp_err = 0; exp_first = 0; c = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("valid_after_start", valid_o, 0);
        exp_done = 1'b0;
        while (!exp_done) begin
            c++;
            finish_i = 1'b0;
            answer_i = OW'($urandom);
            if (c >= first_c && c <= TO + 1 && j < 2*N && $urandom_range(99) < p_fin) begin
                w = ref_gold[j];
                if (j == err_a || j == err_b) begin
                    w = w + 3;
                end else if ($urandom_range(99) < p_err) begin
                    w = $urandom_range(1) ? OW'($urandom) : OW'(w + OW'($urandom_range(4)) - 2);
                end
                finish_i = 1'b1;
                answer_i = w;
                if (!word_ok(w, ref_gold[j])) begin
                    if (exp_err == 0) exp_first = j;
                    exp_err++;
                end
                j++;
                if (j == 2*N) last_e = c;
            end else if (j >= 2*N && $urandom_range(1) == 1) begin
                finish_i = 1'b1;
            end
            if (pokes && c == 3) begin
                load_en = 1'b1; load_sel = 1'b0; load_addr = AW'(4);
                load_data = OW'(~ref_in[4]);
            end
            if (pokes && c == 12) start = 1'b1;
            tick();
            load_en = 1'b0;
            start   = 1'b0;
            if (c <= N) begin
                chk("valid_beat", valid_o, 1);
                chk("x_beat", x_o, ref_in[c-1]);
            end else if (c == N + 1) begin
                chk("valid_end", valid_o, 0);
                chk("x_end", x_o, 0);
            end
            exp_done = (last_e != 0 && last_e <= TO) ? (c >= last_e + 1) : (c >= TO + 1);
            chk("done", done, exp_done);
        end
        tmo = !(last_e != 0 && last_e <= TO);
        chk("timeout", timeout, tmo);
        chk("busy_end", busy, 0);
        if (!tmo) begin
            chk("err_cnt_at_done", err_cnt, exp_err);
            chk("pass", pass, exp_err == 0);
        end else begin
            chk("pass_tout", pass, 0);
        end
        finish_i = 1'b1;
        answer_i = OW'($urandom);
        tick();
        finish_i = 1'b0;
        chk("err_cnt", err_cnt, exp_err);
        if (exp_err != 0) chk("first_err_idx", first_err_idx, exp_first);
        chk("done_hold", done, 1);
    endtask

    initial begin
        rst_n = 1'b0; load_en = 1'b0; load_sel = 1'b0; load_addr = '0;
        load_data = '0; start = 1'b0; finish_i = 1'b0; answer_i = '0;
        tick();
        tick();
        chk("rst_valid", valid_o, 0);
        chk("rst_x", x_o, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_first_err", first_err_idx, 0);
        rst_n = 1'b1;
        tick();

        // Ramp input, zero golden, clean answers then two forced errors
        load_all(0, 0);
        run_frame(100, 1, -1, -1, 0, 1'b0);
        run_frame(100, 1, 5, 40, 0, 1'b0);
        // No output at all: timeout, then restart clears status
        run_frame(0, 1, -1, -1, 0, 1'b0);
        run_frame(100, 10, -1, -1, 0, 1'b1);
        // Finish exactly at the timeout boundary, and one word too late
        run_frame(100, 87, -1, -1, 0, 1'b0);
        run_frame(100, 88, 63, -1, 0, 1'b0);

        // Reset during beat 10, memories survive
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 11; c++) tick();
        chk("beat10_x", x_o, ref_in[10]);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst_valid", valid_o, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_x", x_o, 0);
        chk("midrst_err", err_cnt, 0);
        tick();
        run_frame(100, 1, -1, -1, 0, 1'b0);

        // Randomised frames with fresh vectors
        for (int f = 0; f < 8; f++) begin
            load_all(1, 1);
            run_frame($urandom_range(100, 50), $urandom_range(20, 1),
                      $urandom_range(2*N - 1), -1, $urandom_range(15), f[0]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
